// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipeline stages: word and register
// specifier types, the destination-select encoding, and the link register.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // Destination-register select carried down the pipe from decode.
    typedef enum logic [1:0] {
        RD_RT   = 2'b00,
        RD_RD   = 2'b01,
        RD_LINK = 2'b10,
        RD_NONE = 2'b11
    } regdst_t;

    // Register written by jal.
    localparam regbits_t LINK_REG = 5'd31;

    // One-entry record of the last committed register write.
    typedef struct packed {
        logic     valid;
        regbits_t sel;
        word_t    dat;
    } fwd_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB latch outputs into the writeback stage, and the stage's outputs
// to the register file, forwarding network and datapath status.
interface wb_stage_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
);
    // MEM/WB latch side
    logic    valid_in;
    logic    freeze;
    logic    RegWrite_in;
    regdst_t RegDest_in;
    logic    jal_in;
    logic    lui_in;
    logic    memToReg_in;
    logic    halt_in;
    regbits_t rd_in;
    regbits_t rt_in;
    logic [15:0] imm_in;
    word_t   next_pc_in;
    word_t   dmemload_in;
    word_t   port_out_in;

    // Register file write port
    regbits_t wsel;
    word_t   wdat;
    logic    WEN;

    // Forwarding shadow and status
    logic    fwd_valid;
    regbits_t fwd_sel;
    word_t   fwd_dat;
    logic    halt;
    logic [CNT_W-1:0] retired;

    // Producer of the latch contents / consumer of the stage outputs.
    modport master (
        output valid_in, freeze, RegWrite_in, RegDest_in, jal_in, lui_in,
               memToReg_in, halt_in, rd_in, rt_in, imm_in, next_pc_in,
               dmemload_in, port_out_in,
        input  wsel, wdat, WEN, fwd_valid, fwd_sel, fwd_dat, halt, retired
    );

    // The writeback stage itself.
    modport slave (
        input  valid_in, freeze, RegWrite_in, RegDest_in, jal_in, lui_in,
               memToReg_in, halt_in, rd_in, rt_in, imm_in, next_pc_in,
               dmemload_in, port_out_in,
        output wsel, wdat, WEN, fwd_valid, fwd_sel, fwd_dat, halt, retired
    );

endinterface

// File: rtl/wb_result_mux.sv
// Combinational result-word and destination-register select for writeback.
// dest_ok is high only when the selected destination is a legal, non-$0
// register, so the caller can gate the write enable with it directly.
module wb_result_mux
    import cpu_types_pkg::*;
#(
    parameter regbits_t LINK_SEL = LINK_REG
) (
    input  logic        jal,
    input  logic        lui,
    input  logic        mem_to_reg,
    input  regdst_t     reg_dest,
    input  regbits_t    rd,
    input  regbits_t    rt,
    input  logic [15:0] imm,
    input  word_t       next_pc,
    input  word_t       dmemload,
    input  word_t       port_out,
    output regbits_t    wsel,
    output word_t       wdat,
    output logic        dest_ok
);

    // Result word, priority jal > lui > load > ALU.
    // NOTE: every output of an always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        wdat = port_out;
        if (jal)
            wdat = next_pc;
        else if (lui)
            wdat = {imm, 16'h0000};
        else if (mem_to_reg)
            wdat = dmemload;
    end

    // Destination register; jal overrides the RegDest field.
    always_comb begin
        wsel    = '0;
        dest_ok = 1'b0;
        if (jal) begin
            wsel    = LINK_SEL;
            dest_ok = 1'b1;
        end else begin
            case (reg_dest)
                RD_RT:   begin wsel = rt;       dest_ok = 1'b1; end
                RD_RD:   begin wsel = rd;       dest_ok = 1'b1; end
                RD_LINK: begin wsel = LINK_SEL; dest_ok = 1'b1; end
                default: begin wsel = '0;       dest_ok = 1'b0; end
            endcase
        end
        // $0 is hardwired to zero; never enable a write to it.
        if (wsel == '0)
            dest_ok = 1'b0;
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: drives the register-file write port from the MEM/WB
// latch, keeps a one-entry shadow of the last committed write for
// forwarding, a sticky halt flag and a retired-instruction counter.
module wb_stage #(
    parameter int                       CNT_W    = 32,
    parameter cpu_types_pkg::regbits_t  LINK_REG = cpu_types_pkg::LINK_REG
) (
    input  logic            CLK,
    input  logic            RST,
    wb_stage_if.slave       wb
);
    import cpu_types_pkg::*;

    logic             commit;
    logic             dest_ok;
    logic             wen;
    regbits_t         mux_sel;
    word_t            mux_dat;
    logic             halt_q;
    logic [CNT_W-1:0] retired_q;
    fwd_t             fwd_q;

    wb_result_mux #(
        .LINK_SEL (LINK_REG)
    ) u_mux (
        .jal        (wb.jal_in),
        .lui        (wb.lui_in),
        .mem_to_reg (wb.memToReg_in),
        .reg_dest   (wb.RegDest_in),
        .rd         (wb.rd_in),
        .rt         (wb.rt_in),
        .imm        (wb.imm_in),
        .next_pc    (wb.next_pc_in),
        .dmemload   (wb.dmemload_in),
        .port_out   (wb.port_out_in),
        .wsel       (mux_sel),
        .wdat       (mux_dat),
        .dest_ok    (dest_ok)
    );

    // A held (frozen) instruction commits only on the first unfrozen cycle;
    // nothing commits once halted. A halt instruction never writes, and
    // reset suppresses the write in the same cycle.
    assign commit = wb.valid_in & ~wb.freeze & ~halt_q;
    assign wen    = ~RST & commit & wb.RegWrite_in & ~wb.halt_in & dest_ok;

    // Halt flag, retired counter and forwarding shadow.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            halt_q    <= 1'b0;
            retired_q <= '0;
            fwd_q     <= '0;
        end else begin
            if (commit) begin
                retired_q <= retired_q + CNT_W'(1);
                if (wb.halt_in)
                    halt_q <= 1'b1;
            end
            if (wen)
                fwd_q <= '{valid: 1'b1, sel: mux_sel, dat: mux_dat};
        end
    end

    assign wb.wsel      = mux_sel;
    assign wb.wdat      = mux_dat;
    assign wb.WEN       = wen;
    assign wb.fwd_valid = fwd_q.valid;
    assign wb.fwd_sel   = fwd_q.sel;
    assign wb.fwd_dat   = fwd_q.dat;
    assign wb.halt      = halt_q;
    assign wb.retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a table of single-cycle vectors with
// hand-computed write-port results, then directed multi-cycle sequences for
// freeze, halt, reset priority and counter wrap (on a 4-bit counter build).
module tb_wb_stage;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if #(.CNT_W(32)) bus ();
    wb_stage_if #(.CNT_W(4))  bus4 ();

    wb_stage #(.CNT_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .wb  (bus)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .CLK (clk),
        .RST (rst),
        .wb  (bus4)
    );

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_in    = 1'b0;
        bus.freeze      = 1'b0;
        bus.RegWrite_in = 1'b0;
        bus.RegDest_in  = RD_RT;
        bus.jal_in      = 1'b0;
        bus.lui_in      = 1'b0;
        bus.memToReg_in = 1'b0;
        bus.halt_in     = 1'b0;
        bus.rd_in       = '0;
        bus.rt_in       = '0;
        bus.imm_in      = '0;
        bus.next_pc_in  = '0;
        bus.dmemload_in = '0;
        bus.port_out_in = '0;
    endtask

    task automatic idle_inputs4();
        bus4.valid_in    = 1'b0;
        bus4.freeze      = 1'b0;
        bus4.RegWrite_in = 1'b0;
        bus4.RegDest_in  = RD_RT;
        bus4.jal_in      = 1'b0;
        bus4.lui_in      = 1'b0;
        bus4.memToReg_in = 1'b0;
        bus4.halt_in     = 1'b0;
        bus4.rd_in       = '0;
        bus4.rt_in       = '0;
        bus4.imm_in      = '0;
        bus4.next_pc_in  = '0;
        bus4.dmemload_in = '0;
        bus4.port_out_in = '0;
    endtask

    // Valid ALU write of `dat` to rd (RegDest=rd).
    task automatic drive_write(input logic [4:0] rd, input logic [31:0] dat);
        idle_inputs();
        bus.valid_in    = 1'b1;
        bus.RegWrite_in = 1'b1;
        bus.RegDest_in  = RD_RD;
        bus.rd_in       = rd;
        bus.port_out_in = dat;
    endtask

    typedef struct {
        logic        valid;
        logic        reg_write;
        logic [1:0]  reg_dest;
        logic        jal;
        logic        lui;
        logic        mem;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [31:0] npc;
        logic [31:0] dmem;
        logic [31:0] port;
        logic        exp_wen;
        logic        chk_sel;
        logic [4:0]  exp_sel;
        logic [31:0] exp_dat;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    // Bench-side expectation of the registered state.
    logic [31:0] exp_ret;
    logic        exp_fv;
    logic [4:0]  exp_fs;
    logic [31:0] exp_fd;

    initial begin
        //           val rw  dst   jal lui mem rd     rt     imm       npc            dmem           port           wen chk sel    dat
        vecs[0]  = '{1,  1,  2'b01, 0,  0,  1,  5'd5,  5'd0,  16'h0000, 32'h0,         32'hDEADBEEF,  32'h11111111,  1,  1,  5'd5,  32'hDEADBEEF};
        vecs[1]  = '{1,  1,  2'b00, 1,  0,  0,  5'd0,  5'd3,  16'h0000, 32'h00000104,  32'h0,         32'h22222222,  1,  1,  5'd31, 32'h00000104};
        vecs[2]  = '{1,  1,  2'b01, 0,  1,  0,  5'd9,  5'd0,  16'h1234, 32'h0,         32'h0,         32'h33333333,  1,  1,  5'd9,  32'h12340000};
        vecs[3]  = '{1,  1,  2'b00, 0,  0,  0,  5'd4,  5'd0,  16'h0000, 32'h0,         32'h0,         32'h0000AAAA,  0,  1,  5'd0,  32'h0000AAAA};
        vecs[4]  = '{1,  1,  2'b10, 0,  0,  0,  5'd2,  5'd6,  16'h0000, 32'h0,         32'h0,         32'h00000055,  1,  1,  5'd31, 32'h00000055};
        vecs[5]  = '{1,  1,  2'b11, 0,  0,  0,  5'd2,  5'd6,  16'h0000, 32'h0,         32'h0,         32'h00000066,  0,  0,  5'd0,  32'h00000066};
        vecs[6]  = '{0,  1,  2'b01, 0,  0,  0,  5'd4,  5'd0,  16'h0000, 32'h0,         32'h0,         32'h00000077,  0,  1,  5'd4,  32'h00000077};
        vecs[7]  = '{1,  0,  2'b01, 0,  0,  0,  5'd6,  5'd0,  16'h0000, 32'h0,         32'h0,         32'h00000088,  0,  1,  5'd6,  32'h00000088};
        vecs[8]  = '{1,  1,  2'b01, 1,  1,  1,  5'd7,  5'd8,  16'hBEEF, 32'h00000200,  32'hCAFEF00D,  32'h99999999,  1,  1,  5'd31, 32'h00000200};
        vecs[9]  = '{1,  1,  2'b01, 0,  1,  1,  5'd7,  5'd8,  16'hBEEF, 32'h00000200,  32'hCAFEF00D,  32'h99999999,  1,  1,  5'd7,  32'hBEEF0000};
        vecs[10] = '{1,  1,  2'b00, 0,  0,  0,  5'd7,  5'd12, 16'hBEEF, 32'h00000200,  32'hCAFEF00D,  32'h0BADC0DE,  1,  1,  5'd12, 32'h0BADC0DE};

        // ---------------- reset, with a write presented during it ----------
        rst = 1'b1;
        idle_inputs4();
        drive_write(5'd5, 32'h12345678);
        step();
        #2;
        check("wen_during_reset", bus.WEN, 1'b0);
        step();
        rst = 1'b0;
        check("reset_halt",      bus.halt,      1'b0);
        check("reset_retired",   bus.retired,   32'd0);
        check("reset_fwd_valid", bus.fwd_valid, 1'b0);
        check("reset_fwd_sel",   bus.fwd_sel,   5'd0);
        check("reset_fwd_dat",   bus.fwd_dat,   32'd0);
        check("reset_retired4",  bus4.retired,  4'd0);
        exp_ret = 32'd0;
        exp_fv  = 1'b0;
        exp_fs  = 5'd0;
        exp_fd  = 32'd0;

        // ---------------- table-driven single-cycle vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            idle_inputs();
            bus.valid_in    = vecs[i].valid;
            bus.RegWrite_in = vecs[i].reg_write;
            bus.RegDest_in  = regdst_t'(vecs[i].reg_dest);
            bus.jal_in      = vecs[i].jal;
            bus.lui_in      = vecs[i].lui;
            bus.memToReg_in = vecs[i].mem;
            bus.rd_in       = vecs[i].rd;
            bus.rt_in       = vecs[i].rt;
            bus.imm_in      = vecs[i].imm;
            bus.next_pc_in  = vecs[i].npc;
            bus.dmemload_in = vecs[i].dmem;
            bus.port_out_in = vecs[i].port;
            #2;
            check($sformatf("vec%0d_wen", i),  bus.WEN,  vecs[i].exp_wen);
            check($sformatf("vec%0d_wdat", i), bus.wdat, vecs[i].exp_dat);
            if (vecs[i].chk_sel)
                check($sformatf("vec%0d_wsel", i), bus.wsel, vecs[i].exp_sel);
            step();
            if (vecs[i].valid)
                exp_ret = exp_ret + 32'd1;
            if (vecs[i].exp_wen) begin
                exp_fv = 1'b1;
                exp_fs = vecs[i].exp_sel;
                exp_fd = vecs[i].exp_dat;
            end
            check($sformatf("vec%0d_retired", i),   bus.retired,   exp_ret);
            check($sformatf("vec%0d_fwd_valid", i), bus.fwd_valid, exp_fv);
            check($sformatf("vec%0d_fwd_sel", i),   bus.fwd_sel,   exp_fs);
            check($sformatf("vec%0d_fwd_dat", i),   bus.fwd_dat,   exp_fd);
        end

        // ---------------- freeze for 3 cycles over a write to r7 ----------
        drive_write(5'd7, 32'h00007777);
        bus.freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("freeze%0d_wen", c), bus.WEN, 1'b0);
            step();
            check($sformatf("freeze%0d_retired", c), bus.retired, exp_ret);
            check($sformatf("freeze%0d_fwd_sel", c), bus.fwd_sel, exp_fs);
        end
        bus.freeze = 1'b0;
        #2;
        check("unfreeze_wen", bus.WEN, 1'b1);
        step();
        exp_ret = exp_ret + 32'd1;
        exp_fs  = 5'd7;
        exp_fd  = 32'h00007777;
        check("unfreeze_retired", bus.retired, exp_ret);
        check("unfreeze_fwd_sel", bus.fwd_sel, exp_fs);
        check("unfreeze_fwd_dat", bus.fwd_dat, exp_fd);
        idle_inputs();
        #2;
        check("after_freeze_no_wen", bus.WEN, 1'b0);
        step();
        check("after_freeze_retired", bus.retired, exp_ret);

        // ---------------- halt with RegWrite, then further writes ----------
        drive_write(5'd8, 32'h00008888);
        bus.halt_in = 1'b1;
        #2;
        check("halt_instr_wen", bus.WEN, 1'b0);
        step();
        exp_ret = exp_ret + 32'd1;
        check("halt_set",         bus.halt,    1'b1);
        check("halt_retired",     bus.retired, exp_ret);
        check("halt_fwd_sel",     bus.fwd_sel, exp_fs);
        check("halt_fwd_dat",     bus.fwd_dat, exp_fd);
        for (int c = 0; c < 2; c++) begin
            drive_write(5'd10 + 5'(c), 32'hA0 + 32'(c));
            #2;
            check($sformatf("halted%0d_wen", c), bus.WEN, 1'b0);
            step();
            check($sformatf("halted%0d_halt", c),    bus.halt,    1'b1);
            check($sformatf("halted%0d_retired", c), bus.retired, exp_ret);
            check($sformatf("halted%0d_fwd_sel", c), bus.fwd_sel, exp_fs);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("halt_rst_halt",      bus.halt,      1'b0);
        check("halt_rst_retired",   bus.retired,   32'd0);
        check("halt_rst_fwd_valid", bus.fwd_valid, 1'b0);
        check("halt_rst_fwd_sel",   bus.fwd_sel,   5'd0);
        check("halt_rst_fwd_dat",   bus.fwd_dat,   32'd0);

        // ---------------- reset wins over a same-cycle commit -------------
        drive_write(5'd3, 32'h00000333);
        step();
        check("pre_rst_retired", bus.retired, 32'd1);
        check("pre_rst_fwd_sel", bus.fwd_sel, 5'd3);
        rst = 1'b1;
        #2;
        check("rst_commit_wen", bus.WEN, 1'b0);
        step();
        rst = 1'b0;
        check("rst_commit_retired",   bus.retired,   32'd0);
        check("rst_commit_fwd_valid", bus.fwd_valid, 1'b0);

        // ---------------- reset in the middle of a stall ------------------
        drive_write(5'd4, 32'h00000444);
        step();
        bus.freeze = 1'b1;
        step();
        check("stall_retired", bus.retired, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stall_rst_retired",   bus.retired,   32'd0);
        check("stall_rst_fwd_valid", bus.fwd_valid, 1'b0);
        check("stall_rst_fwd_dat",   bus.fwd_dat,   32'd0);
        idle_inputs();

        // ---------------- 4-bit counter wraps after 16 commits ------------
        bus4.valid_in = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 1)
                check("wrap_first", bus4.retired, 4'd1);
            if (c == 15)
                check("wrap_all_ones", bus4.retired, 4'hF);
            if (c == 16)
                check("wrap_zero", bus4.retired, 4'h0);
        end
        idle_inputs4();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
